// File: rtl/bram_cipher_engine_pkg.sv
// Shared encodings for the BRAM cipher engine: cipher direction and controller states.
package bram_cipher_engine_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bram_cipher_engine_mod_add_unit.sv
// Single registered modular add/subtract stage with a range check on the incoming byte.
module mod_add_unit
  import bram_cipher_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic              mode,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] k,
  input  logic [DATA_W-1:0] mod,
  input  logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [DATA_W-1:0] res,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              range_err
);

  logic [DATA_W:0] sum;
  logic            in_range;

  // k is already reduced below mod, so one correction step is enough in both directions.
  always_comb begin
    sum = '0;
    if (mode == MODE_ENC) begin
      sum = {1'b0, d} + {1'b0, k};
      if (sum >= {1'b0, mod}) sum = sum - {1'b0, mod};
    end else begin
      sum = {1'b0, d} - {1'b0, k};
      if (sum[DATA_W]) sum = sum + {1'b0, mod};
    end
  end

  assign in_range = (d < mod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr        <= 1'b0;
      res       <= '0;
      wr_addr   <= '0;
      range_err <= 1'b0;
    end else begin
      wr        <= vld;
      range_err <= vld & ~in_range;
      if (vld) begin
        res     <= in_range ? sum[DATA_W-1:0] : d;
        wr_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/bram_cipher_engine.sv
// Streams len bytes from a source BRAM through a modular-add cipher into a destination BRAM.
module bram_cipher_engine
  import bram_cipher_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1,
  parameter int LED_W  = 16
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] mod,
  input  logic              key_valid,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_dout,
  output logic              dst_en,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LED_W-1:0]  led
);

  state_t            state;
  logic              mode_r;
  logic [ADDR_W-1:0] len_r;
  logic [DATA_W-1:0] k_r;
  logic [DATA_W-1:0] mod_r;
  logic              key_loaded;
  logic [ADDR_W:0]   wr_cnt;
  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];
  logic [LED_W-1:0]  led_next;
  logic              unit_err;

  // Read-valid and address shift register, aligned with the source BRAM latency.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      vld[0]       <= 1'b0;
      addr_pipe[0] <= '0;
    end else begin
      vld[0]       <= src_en;
      addr_pipe[0] <= src_addr;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
          vld[gi]       <= 1'b0;
          addr_pipe[gi] <= '0;
        end else begin
          vld[gi]       <= vld[gi-1];
          addr_pipe[gi] <= addr_pipe[gi-1];
        end
      end
    end
  endgenerate

  mod_add_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mod_add (
    .clk       (CLK100MHZ),
    .rst_n     (reset),
    .vld       (vld[RD_LAT-1]),
    .mode      (mode_r),
    .d         (src_dout),
    .k         (k_r),
    .mod       (mod_r),
    .addr      (addr_pipe[RD_LAT-1]),
    .wr        (dst_we),
    .res       (dst_din),
    .wr_addr   (dst_addr),
    .range_err (unit_err)
  );

  assign dst_en = dst_we;

  // Bar j lights once wr_cnt/len reaches (j+1)/LED_W; wr_cnt only grows, so bars never drop.
  generate
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
      assign led_next[gi] = (32'(wr_cnt) * 32'(LED_W)) >= (32'(gi + 1) * 32'(len_r));
    end
  endgenerate

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      src_en     <= 1'b0;
      src_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      led        <= '0;
      mode_r     <= MODE_ENC;
      len_r      <= '0;
      k_r        <= '0;
      mod_r      <= '0;
      key_loaded <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (unit_err) err <= 1'b1;
      if (dst_we) wr_cnt <= wr_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r     <= mode;
            len_r      <= len;
            err        <= 1'b0;
            led        <= '0;
            busy       <= 1'b1;
            wr_cnt     <= '0;
            key_loaded <= 1'b0;
            state      <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (!key_loaded) begin
            if (key_valid) begin
              if (mod == '0 || len_r == '0) begin
                err   <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                led   <= '1;
                state <= ST_DONE;
              end else begin
                k_r        <= key;
                mod_r      <= mod;
                key_loaded <= 1'b1;
              end
            end
          end else if (k_r >= mod_r) begin
            k_r <= k_r - mod_r;
          end else begin
            src_en   <= 1'b1;
            src_addr <= '0;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          led <= led_next;
          if (src_addr == len_r - 1'b1) begin
            src_en <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            src_addr <= src_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          led <= led_next;
          if (vld == '0 && !dst_we) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            led   <= '1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
